nrzi_unstuff_decoder: RTL and testbench

Receive-path line decoder for the USB SIE. It decodes NRZI data one bit per strobe, removes stuffed bits, flags bit-stuff violations and detects End-Of-Packet (SE0 for N bit times followed by J). It sits between the clock-recovery/differential-receiver stage and the RX shift register, and runs in the clk12 domain. It is the parametrised successor of the plain NRZI decoder: it adds sample-enable gating, configurable unstuffing, error reporting and EOP detection.

---
 rtl/usb_rx_pkg.sv | 18 +
 rtl/nrzi_unstuff_decoder.sv | 109 ++++++++++
 tb/tb_nrzi_unstuff_decoder.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/usb_rx_pkg.sv
// Shared constants and helpers for the USB receive path.
// Line levels, stuffing length and EOP length used by the SIE.
package usb_rx_pkg;

    localparam int   USB_STUFF_LEN   = 6;
    localparam int   USB_EOP_SE0_LEN = 2;
    localparam logic USB_LEVEL_J     = 1'b1;

    // Recover one logical bit from the previous and current line level.
    function automatic logic nrzi_bit(input logic prev_level,
                                      input logic level,
                                      input logic zero_is_transition);
        logic changed;
        changed = prev_level ^ level;
        return zero_is_transition ? ~changed : changed;
    endfunction

endpackage

// File: rtl/nrzi_unstuff_decoder.sv
// NRZI decoder with bit unstuffing, stuff-error flagging and EOP detection.
// One line sample is consumed per sampleEn strobe; all outputs are registered.
module nrzi_unstuff_decoder
    import usb_rx_pkg::*;
#(
    parameter logic INITIAL_VALUE      = USB_LEVEL_J,
    parameter logic ZERO_AS_TRANSITION = 1'b1,
    parameter int   STUFF_LEN          = USB_STUFF_LEN,
    parameter int   EOP_SE0_LEN        = USB_EOP_SE0_LEN
) (
    input  logic clk12,
    input  logic RST,
    input  logic sampleEn,
    input  logic dataJK,
    input  logic se0,
    output logic dataOut,
    output logic dataValid,
    output logic stuffError,
    output logic eopDetected
);

    localparam int ONES_W = (STUFF_LEN > 0) ? $clog2(STUFF_LEN + 1) : 1;
    localparam int SE0_W  = (EOP_SE0_LEN > 0) ? $clog2(EOP_SE0_LEN + 1) : 1;
    localparam logic [ONES_W-1:0] STUFF_MAX = ONES_W'(STUFF_LEN);
    localparam logic [SE0_W-1:0]  SE0_MAX   = SE0_W'(EOP_SE0_LEN);
    localparam logic [ONES_W-1:0] ONES_ONE  = ONES_W'(1);
    localparam logic [SE0_W-1:0]  SE0_ONE   = SE0_W'(1);

    logic              prev_level_q, prev_level_d;
    logic [ONES_W-1:0] ones_cnt_q,   ones_cnt_d;
    logic [SE0_W-1:0]  se0_cnt_q,    se0_cnt_d;
    logic              data_out_q,   data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              stuff_err_q,  stuff_err_d;
    logic              eop_q,        eop_d;
    logic              bit_s;

    assign bit_s = nrzi_bit(prev_level_q, dataJK, ZERO_AS_TRANSITION);

    // Next-state decode of one line sample: SE0 counting, EOP, unstuffing.
    always_comb begin
        prev_level_d = prev_level_q;
        ones_cnt_d   = ones_cnt_q;
        se0_cnt_d    = se0_cnt_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        stuff_err_d  = 1'b0;
        eop_d        = 1'b0;
        if (sampleEn) begin
            if (se0) begin
                if (se0_cnt_q != SE0_MAX) begin
                    se0_cnt_d = se0_cnt_q + SE0_ONE;
                end else begin
                    se0_cnt_d = se0_cnt_q;
                end
            end else if ((se0_cnt_q >= SE0_MAX) && dataJK) begin
                eop_d        = 1'b1;
                prev_level_d = INITIAL_VALUE;
                ones_cnt_d   = '0;
                se0_cnt_d    = '0;
            end else begin
                // Short SE0 or SE0 followed by K falls through as ordinary data.
                se0_cnt_d    = '0;
                prev_level_d = dataJK;
                if ((STUFF_LEN > 0) && (ones_cnt_q == STUFF_MAX)) begin
                    ones_cnt_d  = '0;
                    stuff_err_d = bit_s;
                end else begin
                    data_valid_d = 1'b1;
                    data_out_d   = bit_s;
                    if (bit_s && (STUFF_LEN > 0)) begin
                        ones_cnt_d = ones_cnt_q + ONES_ONE;
                    end else begin
                        ones_cnt_d = '0;
                    end
                end
            end
        end else begin
            se0_cnt_d = se0_cnt_q;
        end
    end

    // State and output registers; RST takes priority over any sample.
    always_ff @(posedge clk12) begin
        if (RST) begin
            prev_level_q <= INITIAL_VALUE;
            ones_cnt_q   <= '0;
            se0_cnt_q    <= '0;
            data_out_q   <= INITIAL_VALUE;
            data_valid_q <= 1'b0;
            stuff_err_q  <= 1'b0;
            eop_q        <= 1'b0;
        end else begin
            prev_level_q <= prev_level_d;
            ones_cnt_q   <= ones_cnt_d;
            se0_cnt_q    <= se0_cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            stuff_err_q  <= stuff_err_d;
            eop_q        <= eop_d;
        end
    end

    assign dataOut     = data_out_q;
    assign dataValid   = data_valid_q;
    assign stuffError  = stuff_err_q;
    assign eopDetected = eop_q;

endmodule

// File: tb/tb_nrzi_unstuff_decoder.sv
// Scoreboard bench: stimulus queues expected pulses with their due cycle,
// a negedge monitor compares every cycle for both the stuffing and no-stuffing builds.
module tb_nrzi_unstuff_decoder;
    import usb_rx_pkg::*;

    localparam logic [1:0] K_NONE = 2'd0;
    localparam logic [1:0] K_DATA = 2'd1;
    localparam logic [1:0] K_SERR = 2'd2;
    localparam logic [1:0] K_EOP  = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic        b;
        logic [31:0] due;
        logic [15:0] id;
    } exp_t;

    logic clk12 = 1'b0;
    logic RST = 1'b1;
    logic sampleEn = 1'b0;
    logic sen0 = 1'b0;
    logic dataJK = 1'b1;
    logic se0 = 1'b0;
    logic dataOut, dataValid, stuffError, eopDetected;
    logic z_dataOut, z_dataValid, z_stuffError, z_eopDetected;

    int total = 0;
    int bad = 0;
    int step = 0;
    logic [31:0] cyc = 32'd0;
    exp_t q_main[$];
    exp_t q_z[$];

    nrzi_unstuff_decoder #(
        .INITIAL_VALUE(USB_LEVEL_J), .ZERO_AS_TRANSITION(1'b1),
        .STUFF_LEN(USB_STUFF_LEN), .EOP_SE0_LEN(USB_EOP_SE0_LEN)
    ) dut (
        .clk12(clk12), .RST(RST), .sampleEn(sampleEn), .dataJK(dataJK), .se0(se0),
        .dataOut(dataOut), .dataValid(dataValid), .stuffError(stuffError),
        .eopDetected(eopDetected)
    );

    nrzi_unstuff_decoder #(
        .INITIAL_VALUE(USB_LEVEL_J), .ZERO_AS_TRANSITION(1'b1),
        .STUFF_LEN(0), .EOP_SE0_LEN(USB_EOP_SE0_LEN)
    ) dut0 (
        .clk12(clk12), .RST(RST), .sampleEn(sen0), .dataJK(dataJK), .se0(se0),
        .dataOut(z_dataOut), .dataValid(z_dataValid), .stuffError(z_stuffError),
        .eopDetected(z_eopDetected)
    );

    always #5 clk12 = ~clk12;

    always @(posedge clk12) cyc <= cyc + 32'd1;

    function automatic logic [3:0] enc(input exp_t e);
        case (e.kind)
            K_DATA:  return {3'b100, e.b};
            K_SERR:  return 4'b0100;
            K_EOP:   return 4'b0010;
            default: return 4'b0000;
        endcase
    endfunction

    // Monitor: expected pulse on its due cycle, silence on every other cycle.
    always @(negedge clk12) begin
        logic [3:0] got, want;
        exp_t e;
        int id;
        got = {dataValid, stuffError, eopDetected, dataValid & dataOut};
        want = 4'b0000;
        id = -1;
        if (q_main.size() > 0 && q_main[0].due == cyc) begin
            e = q_main.pop_front();
            want = enc(e);
            id = int'(e.id);
        end
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL main cyc=%0d step=%0d got{v,s,e,d}=%b exp=%b", cyc, id, got, want);
        end
        got = {z_dataValid, z_stuffError, z_eopDetected, z_dataValid & z_dataOut};
        want = 4'b0000;
        id = -1;
        if (q_z.size() > 0 && q_z[0].due == cyc) begin
            e = q_z.pop_front();
            want = enc(e);
            id = int'(e.id);
        end
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL nostuff cyc=%0d step=%0d got{v,s,e,d}=%b exp=%b", cyc, id, got, want);
        end
    end

    task automatic smp(input logic lvl, input logic s0, input logic [1:0] k, input logic b);
        @(posedge clk12);
        #1;
        sampleEn = 1'b1;
        sen0 = 1'b0;
        dataJK = lvl;
        se0 = s0;
        step++;
        if (k != K_NONE) q_main.push_back('{kind: k, b: b, due: cyc + 32'd1, id: 16'(step)});
    endtask

    task automatic smp0(input logic lvl, input logic [1:0] k, input logic b);
        @(posedge clk12);
        #1;
        sampleEn = 1'b0;
        sen0 = 1'b1;
        dataJK = lvl;
        se0 = 1'b0;
        step++;
        if (k != K_NONE) q_z.push_back('{kind: k, b: b, due: cyc + 32'd1, id: 16'(step)});
    endtask

    task automatic idle(input logic lvl, input logic s0);
        @(posedge clk12);
        #1;
        sampleEn = 1'b0;
        sen0 = 1'b0;
        dataJK = lvl;
        se0 = s0;
    endtask

    task automatic check_reset(input string nm);
        total++;
        if ({dataOut, dataValid, stuffError, eopDetected} !== 4'b1000) begin
            bad++;
            $display("FAIL %s main got{o,v,s,e}=%b exp=1000", nm,
                     {dataOut, dataValid, stuffError, eopDetected});
        end
        total++;
        if ({z_dataOut, z_dataValid, z_stuffError, z_eopDetected} !== 4'b1000) begin
            bad++;
            $display("FAIL %s nostuff got{o,v,s,e}=%b exp=1000", nm,
                     {z_dataOut, z_dataValid, z_stuffError, z_eopDetected});
        end
    endtask

    initial begin
        repeat (3) @(posedge clk12);
        #1;
        RST = 1'b0;
        check_reset("reset_state");

        // J,K,K,J,K against initial J
        smp(1'b1, 1'b0, K_DATA, 1'b1);
        smp(1'b0, 1'b0, K_DATA, 1'b0);
        smp(1'b0, 1'b0, K_DATA, 1'b1);
        smp(1'b1, 1'b0, K_DATA, 1'b0);
        smp(1'b0, 1'b0, K_DATA, 1'b0);

        // six ones, stuffed zero, then a real zero
        for (int i = 0; i < 6; i++) smp(1'b0, 1'b0, K_DATA, 1'b1);
        smp(1'b1, 1'b0, K_NONE, 1'b0);
        smp(1'b0, 1'b0, K_DATA, 1'b0);

        // seven ones: stuff violation, decoding continues
        for (int i = 0; i < 6; i++) smp(1'b0, 1'b0, K_DATA, 1'b1);
        smp(1'b0, 1'b0, K_SERR, 1'b0);
        smp(1'b1, 1'b0, K_DATA, 1'b0);
        smp(1'b0, 1'b0, K_DATA, 1'b0);

        // EOP, then K decodes against reloaded J
        smp(1'b0, 1'b1, K_NONE, 1'b0);
        smp(1'b0, 1'b1, K_NONE, 1'b0);
        smp(1'b1, 1'b0, K_EOP, 1'b0);
        smp(1'b0, 1'b0, K_DATA, 1'b0);

        // short SE0 then J; SE0,SE0,K; SE0 then J
        smp(1'b1, 1'b1, K_NONE, 1'b0);
        smp(1'b1, 1'b0, K_DATA, 1'b0);
        smp(1'b0, 1'b1, K_NONE, 1'b0);
        smp(1'b0, 1'b1, K_NONE, 1'b0);
        smp(1'b0, 1'b0, K_DATA, 1'b0);
        smp(1'b1, 1'b1, K_NONE, 1'b0);
        smp(1'b1, 1'b0, K_DATA, 1'b0);

        // line activity while sampleEn low must be ignored
        idle(1'b0, 1'b1);
        idle(1'b0, 1'b1);
        idle(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) smp(1'b1, 1'b0, K_DATA, 1'b1);

        // RST mid-packet together with a sample
        @(posedge clk12);
        #1;
        RST = 1'b1;
        sampleEn = 1'b1;
        sen0 = 1'b1;
        dataJK = 1'b1;
        se0 = 1'b0;
        @(posedge clk12);
        #1;
        RST = 1'b0;
        sampleEn = 1'b0;
        sen0 = 1'b0;
        check_reset("mid_reset");
        for (int i = 0; i < 6; i++) smp(1'b1, 1'b0, K_DATA, 1'b1);
        smp(1'b0, 1'b0, K_NONE, 1'b0);
        smp(1'b1, 1'b0, K_DATA, 1'b0);
        idle(1'b0, 1'b0);

        // unstuffing disabled: eight ones then a zero
        for (int i = 0; i < 8; i++) smp0(1'b1, K_DATA, 1'b1);
        smp0(1'b0, K_DATA, 1'b0);
        idle(1'b1, 1'b0);

        repeat (4) idle(1'b1, 1'b0);
        total++;
        if (q_main.size() != 0 || q_z.size() != 0) begin
            bad++;
            $display("FAIL drain pending main=%0d nostuff=%0d exp=0", q_main.size(), q_z.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
